multi_debounce: RTL
===================

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of independent input channels (1..32).
REQ-002 The block SHALL have parameter CNT_N, default 64, giving the number of consecutive cycles an input must differ from its debounced level before the level flips (2..65535).
REQ-003 The block SHALL have parameter HOLD_N, default 50000000, giving the number of cycles the debounced level must stay high before the first hold pulse (>= 2).
REQ-004 The block SHALL have parameter REP_N, default 10000000, giving the hold auto-repeat period in cycles; 0 disables repeat.
REQ-005 The block SHALL have port i_clk, input, width 1, as its single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port i_rst, input, width 1, as its asynchronous, active-high reset.
REQ-007 The block SHALL have port i_in, input, width N_CH, carrying the raw bouncy inputs.
REQ-008 The block SHALL have port o_level, output, width N_CH, carrying the debounced level per channel.
REQ-009 The block SHALL have ports o_pos and o_neg, output, width N_CH, carrying one-cycle rise and fall pulses per channel.
REQ-010 The block SHALL have port o_hold, output, width N_CH, carrying one-cycle long-press and repeat pulses per channel.
REQ-011 The block SHALL have port o_any, output, width 1, equal to the OR of o_level.

Function
REQ-012 Channels SHALL be fully independent; no channel's inputs affect another's outputs except through o_any.
REQ-013 Each channel SHALL count consecutive sampled cycles where input != o_level; any matching sample SHALL clear the count to 0.
REQ-014 The count SHALL toggle o_level when the CNT_N-th consecutive mismatching sample is registered, giving CNT_N cycles of latency; glitches shorter than CNT_N cycles SHALL be ignored.
REQ-015 o_pos or o_neg SHALL assert in exactly the cycle o_level changes, and for one cycle only; both SHALL never be high together on one channel.
REQ-016 Each channel SHALL run an FSM with states RELEASED, PRESSED and HELD: RELEASED->PRESSED on rise; PRESSED->HELD after HOLD_N cycles high; PRESSED or HELD->RELEASED on fall.
REQ-017 o_hold SHALL pulse on the PRESSED->HELD transition, at HOLD_N cycles after o_pos.
REQ-018 In HELD with REP_N>0, o_hold SHALL pulse every REP_N cycles thereafter; with REP_N=0 it SHALL stay low.
REQ-019 A fall SHALL clear the hold counter, and o_hold SHALL be low in any cycle in which o_neg is high.
REQ-020 All counters SHALL be sized $clog2(max+1) and SHALL never wrap; the hold counter restarts at 0 on each repeat pulse.

Reset
REQ-021 Asserting i_rst SHALL immediately clear, without waiting for a clock edge: every counter, the FSMs (to RELEASED), o_level, o_pos, o_neg, o_hold and o_any.
REQ-022 Reset release SHALL itself produce no pulse; an input already high SHALL produce o_pos CNT_N cycles after release.
REQ-023 Reset asserted mid-count or mid-hold SHALL discard all progress.

Configuration
REQ-024 Macro MULTI_DEBOUNCE_SYNC_EN defined: each i_in bit SHALL pass through a 2-flop synchroniser (reset to 0) before the counter, adding exactly 2 cycles of latency.
REQ-025 Macro MULTI_DEBOUNCE_SYNC_EN undefined: i_in SHALL feed the counter directly, and latency SHALL be as in REQ-014.

Structure
REQ-026 Package debounce_pkg SHALL hold the FSM enum state_t (ST_RELEASED, ST_PRESSED, ST_HELD) and the default parameter constants.
REQ-027 A sub-module debounce_ch SHALL implement one channel: synchroniser, counter, FSM and pulse outputs.
REQ-028 multi_debounce SHALL instantiate N_CH copies of debounce_ch in a generate loop, and o_any SHALL be registered-free combinational OR.

Verification (bench: N_CH=4, CNT_N=4, HOLD_N=10, REP_N=3, sync off)
REQ-029 Scenario: ch0 driven high from reset release, held. Required: o_level[0] and o_pos[0] rise at edge 4, o_hold[0] pulses at edges 14, 17 and 20.
REQ-030 Scenario: ch1 high for 3 cycles, low for 1, repeated 5 times. Required: o_level[1], o_pos[1] and o_hold[1] stay 0 throughout.
REQ-031 Scenario: ch2 high 8 cycles, then low. Required: o_pos[2] pulses, no o_hold[2] pulse, and o_neg[2] pulses 4 cycles after the fall; o_any follows o_level[2].
REQ-032 Scenario: ch3 held into HELD, with i_rst pulsed for 1 cycle mid-repeat. Required: all outputs 0 immediately, no pulse on release, and o_pos[3] 4 cycles later.
REQ-033 Scenario: REP_N=0, ch0 held 40 cycles. Required: exactly one o_hold[0] pulse.
REQ-034 Scenario: rerun REQ-029 with MULTI_DEBOUNCE_SYNC_EN defined. Required: every event occurs 2 cycles later (edges 6, 16, 19, 22).

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state type and default parameters for multi_debounce
package debounce_pkg;
  typedef enum logic [1:0] {ST_RELEASED, ST_PRESSED, ST_HELD} state_t;
  localparam int N_CH_DEF   = 4;
  localparam int CNT_N_DEF  = 64;
  localparam int HOLD_N_DEF = 50000000;
  localparam int REP_N_DEF  = 10000000;
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one debounce channel (optional synchroniser via MULTI_DEBOUNCE_SYNC_EN, counter, hold FSM, pulses)
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int CNT_N  = CNT_N_DEF,
  parameter int HOLD_N = HOLD_N_DEF,
  parameter int REP_N  = REP_N_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic pos,
  output logic neg,
  output logic hold
);
  localparam int CW   = $clog2(CNT_N + 1);
  localparam int HMAX = HOLD_N > REP_N ? HOLD_N : REP_N;
  localparam int HW   = $clog2(HMAX + 1);
  logic s, diff, flip, rise, fall, hold_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  state_t state, state_nxt;
`ifdef MULTI_DEBOUNCE_SYNC_EN
  logic [1:0] sync;
  // two-flop synchroniser ahead of the counter
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else sync <= {sync[0], in};
  assign s = sync[1];
`else
  assign s = in;
`endif
  // mismatch counter, level flip detection and hold FSM next state
  always_comb begin
    diff      = s != level;
    flip      = diff && cnt == CW'(CNT_N - 1);
    cnt_nxt   = (diff && !flip) ? cnt + 1'b1 : '0;
    rise      = flip && !level;
    fall      = flip && level;
    state_nxt = state;
    hcnt_nxt  = hcnt;
    hold_nxt  = 1'b0;
    if (fall) begin
      state_nxt = ST_RELEASED;
      hcnt_nxt  = '0;
    end else if (rise) begin
      state_nxt = ST_PRESSED;
      hcnt_nxt  = '0;
    end else if (state == ST_PRESSED) begin
      state_nxt = hcnt == HW'(HOLD_N - 1) ? ST_HELD : ST_PRESSED;
      hold_nxt  = hcnt == HW'(HOLD_N - 1);
      hcnt_nxt  = hold_nxt ? '0 : hcnt + 1'b1;
    end else if (state == ST_HELD && REP_N > 0) begin
      hold_nxt = hcnt == HW'(REP_N - 1);
      hcnt_nxt = hold_nxt ? '0 : hcnt + 1'b1;
    end
  end
  // channel state and registered pulse outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt   <= '0;
      hcnt  <= '0;
      state <= ST_RELEASED;
      level <= 1'b0;
      pos   <= 1'b0;
      neg   <= 1'b0;
      hold  <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      hcnt  <= hcnt_nxt;
      state <= state_nxt;
      level <= level ^ flip;
      pos   <= rise;
      neg   <= fall;
      hold  <= hold_nxt;
    end
endmodule

// File: rtl/multi_debounce.sv
// multi_debounce: N_CH independent debounce channels with press/hold pulses (MULTI_DEBOUNCE_SYNC_EN adds input sync)
module multi_debounce
  import debounce_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int CNT_N  = CNT_N_DEF,
  parameter int HOLD_N = HOLD_N_DEF,
  parameter int REP_N  = REP_N_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_in,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_pos,
  output logic [N_CH-1:0] o_neg,
  output logic [N_CH-1:0] o_hold,
  output logic            o_any
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(.CNT_N(CNT_N), .HOLD_N(HOLD_N), .REP_N(REP_N)) u_ch (
      .clk(i_clk), .rst(i_rst), .in(i_in[i]),
      .level(o_level[i]), .pos(o_pos[i]), .neg(o_neg[i]), .hold(o_hold[i])
    );
  end
  assign o_any = |o_level;
endmodule
